// File: rtl/pdm_cic_dec.sv
// Stereo PDM-to-PCM CIC decimator: per-channel N-stage integrator banks at PDM rate,
// and one comb subtractor shared by both channels and sequenced by a small FSM.
module pdm_cic_dec #(
  parameter int N  = 3,
  parameter int R  = 64,
  parameter int W  = 20,
  parameter int OW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 din_i,
  input  logic                 en_left_i,
  input  logic                 en_right_i,
  output logic signed [OW-1:0] out_left_o,
  output logic signed [OW-1:0] out_right_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 overrun_o,
  output logic [1:0]           state_o
);

  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam int SW = $clog2(2 * N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SNAP = 2'd1,
    S_COMB = 2'd2,
    S_LOAD = 2'd3
  } state_e;

  // Handshake: a sample is transferred at a rising edge where out_valid_o && out_ready_i.
  // out_valid_o and the data stay stable until then; a LOAD while still pending
  // overwrites the data and pulses overrun_o, unless that same edge is the transfer.

  state_e                state_q, state_d;
  logic [SW-1:0]         step_q, step_d;
  logic [CW-1:0]         dec_cnt_q, dec_cnt_d;
  logic signed [W-1:0]   int_l_q [N];
  logic signed [W-1:0]   int_l_d [N];
  logic signed [W-1:0]   int_r_q [N];
  logic signed [W-1:0]   int_r_d [N];
  logic signed [W-1:0]   dly_q [2*N];
  logic signed [W-1:0]   dly_d [2*N];
  logic signed [W-1:0]   x_l_q, x_l_d;
  logic signed [W-1:0]   x_r_q, x_r_d;
  logic signed [OW-1:0]  out_l_q, out_l_d;
  logic signed [OW-1:0]  out_r_q, out_r_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic signed [W-1:0]   pdm_step;
  logic                  dec_evt;
  logic                  comb_right;
  logic signed [W-1:0]   x_sel;
  logic signed [W-1:0]   diff;

  assign pdm_step = din_i ? W'(1) : {W{1'b1}};
  assign dec_evt  = en_right_i && (dec_cnt_q == CW'(R - 1));

  // Steps 0..N-1 belong to the left channel, N..2N-1 to the right; the delay
  // line is laid out in the same order so the step counter indexes it directly.
  assign comb_right = (step_q >= SW'(N));
  assign x_sel      = comb_right ? x_r_q : x_l_q;
  assign diff       = x_sel - dly_q[step_q];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      int_l_d[k] = int_l_q[k];
      int_r_d[k] = int_r_q[k];
    end
    dec_cnt_d = dec_cnt_q;
    if (en_left_i) begin
      int_l_d[0] = int_l_q[0] + pdm_step;
      for (int k = 1; k < N; k++) int_l_d[k] = int_l_q[k] + int_l_q[k-1];
    end
    if (en_right_i) begin
      int_r_d[0] = int_r_q[0] + pdm_step;
      for (int k = 1; k < N; k++) int_r_d[k] = int_r_q[k] + int_r_q[k-1];
      dec_cnt_d = dec_cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_l_d   = x_l_q;
    x_r_d   = x_r_q;
    for (int s = 0; s < 2 * N; s++) dly_d[s] = dly_q[s];
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && out_ready_i) valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dec_evt) state_d = S_SNAP;
      end
      S_SNAP: begin
        x_l_d   = int_l_q[N-1];
        x_r_d   = int_r_q[N-1];
        step_d  = '0;
        state_d = S_COMB;
      end
      S_COMB: begin
        dly_d[step_q] = x_sel;
        if (comb_right) x_r_d = diff;
        else            x_l_d = diff;
        if (step_q == SW'(2 * N - 1)) state_d = S_LOAD;
        else                          step_d  = step_q + SW'(1);
      end
      S_LOAD: begin
        out_l_d = x_l_q[W-1 -: OW];
        out_r_d = x_r_q[W-1 -: OW];
        valid_d = 1'b1;
        ovr_d   = valid_q && !out_ready_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      dec_cnt_q <= '0;
      for (int k = 0; k < N; k++) begin
        int_l_q[k] <= '0;
        int_r_q[k] <= '0;
      end
      for (int s = 0; s < 2 * N; s++) dly_q[s] <= '0;
      x_l_q     <= '0;
      x_r_q     <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      dec_cnt_q <= dec_cnt_d;
      for (int k = 0; k < N; k++) begin
        int_l_q[k] <= int_l_d[k];
        int_r_q[k] <= int_r_d[k];
      end
      for (int s = 0; s < 2 * N; s++) dly_q[s] <= dly_d[s];
      x_l_q     <= x_l_d;
      x_r_q     <= x_r_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out_left_o  = out_l_q;
  assign out_right_o = out_r_q;
  assign out_valid_o = valid_q;
  assign overrun_o   = ovr_q;
  assign state_o     = state_q;

endmodule
